timer: RTL and testbench
========================

TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, which sets the width of PRESET and COUNT; legal range is 8..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port addr, input, 2 bits: word select. 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 SHALL have port we, input, 1 bit: write strobe from the CPU bridge.
REQ-006 SHALL have port din, input, 32 bits: write data.
REQ-007 SHALL have port dout, output, 32 bits: read data, combinational from addr.
REQ-008 SHALL have port irq, output, 1 bit: interrupt request to the mips core.

Function
REQ-009 SHALL define CTRL fields as follows; all other CTRL bits read 0.
- bit0 EN: enable.
- bits2:1 MODE: 0 one-shot, 1 auto-reload, 2/3 behave as 0.
- bit3 IM: interrupt mask.
REQ-010 SHALL handle writes on the rising edge with we=1: addr 0 writes CTRL[3:0]; addr 1 writes PRESET[CNT_W-1:0]; addr 2 and 3 are ignored.
REQ-011 SHALL drive dout as CTRL, PRESET or COUNT (zero-extended) for addr 0, 1 or 2, and 0 for addr 3.
REQ-012 SHALL use the FSM states IDLE, LOAD, CNT and INT.
REQ-013 SHALL make these transitions:
- IDLE goes to LOAD when EN=1.
- LOAD sets COUNT<=PRESET and goes to CNT.
- CNT goes to IDLE when EN=0, holding COUNT.
- Otherwise CNT goes to INT when COUNT==0, else COUNT<=COUNT-1.
REQ-014 SHALL set irq_flag on the CNT->INT edge.
REQ-015 SHALL, in INT, return to IDLE next cycle:
- MODE 0: clear EN; irq_flag stays set until any CTRL write.
- MODE 1: keep EN; clear irq_flag on leaving INT, giving a one-cycle pulse.
REQ-016 SHALL drive irq = irq_flag & IM, registered with no combinational path from din.
REQ-017 SHALL give a CPU write to CTRL in the same cycle as the INT-state EN clear priority: the written value wins.
REQ-018 SHALL NOT let a PRESET write during CNT affect the running COUNT; the new value applies at the next LOAD.
REQ-019 SHALL make COUNT wrap-free: it never decrements below 0.
REQ-020 SHALL handle PRESET=0 as LOAD -> CNT (COUNT=0) -> INT on the next edge.
REQ-021 SHALL have a total latency from the edge that sets EN to irq high of PRESET+3 edges (IDLE->LOAD, LOAD->CNT, PRESET decrements, CNT->INT).

Reset
REQ-022 SHALL, on reset=0, immediately and asynchronously force state=IDLE, CTRL=0, PRESET=0, COUNT=0 and irq_flag=0, so irq=0 and dout reads 0 at every address.
REQ-023 SHALL apply REQ-022 from any state, including mid-CNT and INT, with no residual interrupt after release.
REQ-024 SHALL resume operation on the first rising edge after reset rises.

Configuration
REQ-025 SHALL support macro TIMER_IRQ_EN.
- Defined: irq behaves per REQ-014..REQ-016.
- Undefined: irq is tied 0, IM is not stored and reads 0, and the FSM and COUNT behave identically.

Structure
REQ-026 SHALL place the following in shared package timer_pkg:
- state enum (IDLE, LOAD, CNT, INT);
- register offsets (CTRL_ADDR=0, PRESET_ADDR=1, COUNT_ADDR=2);
- CTRL bit positions;
- mode constants (MODE_ONESHOT=0, MODE_RELOAD=1).
REQ-027 SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-028 SHALL cover one-shot:
- Stimulus: PRESET=3, then CTRL=0b1001 written at edge 0.
- Response: COUNT=3,2,1,0 after edges 2..5; irq=1 after edge 6; EN=0 after edge 7; irq held until a CTRL write of 0 drops it next edge.
REQ-029 SHALL cover auto-reload:
- Stimulus: PRESET=2, CTRL=0b1011.
- Response: irq is a 1-cycle pulse every 6 cycles (INT->IDLE->LOAD->CNT 2,1,0->INT), and EN stays 1.
REQ-030 SHALL cover disable mid-count:
- Stimulus: PRESET=10; write CTRL=0 when COUNT=5.
- Response: IDLE next edge, COUNT reads 5, irq never asserts.
REQ-031 SHALL cover PRESET edge cases:
- PRESET=0 with EN: irq=1 three edges after EN is set.
- PRESET write to 7 during CNT: the current run is unaffected; the next reload gives COUNT=7.
REQ-032 SHALL cover reset mid-INT:
- Stimulus: drive reset=0 between clock edges while irq=1.
- Response: irq=0 and CTRL/PRESET/COUNT read 0 without a clock edge.
REQ-033 SHALL cover the masked and compiled-out cases:
- IM=0: irq stays 0 while the FSM still reaches INT.
- TIMER_IRQ_EN undefined: irq constant 0 in all scenarios, and CTRL bit3 reads 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable countdown timer.
// State encoding, register offsets, CTRL bit positions and mode codes.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_e;

   localparam logic [1:0] CTRL_ADDR   = 2'd0;
   localparam logic [1:0] PRESET_ADDR = 2'd1;
   localparam logic [1:0] COUNT_ADDR  = 2'd2;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer.sv
// Programmable countdown timer with one-shot / auto-reload modes.
// Ports: clk, reset (async, active-low), addr/we/din (CPU write),
//   dout (comb. read of CTRL/PRESET/COUNT), irq (to core).
// Macro TIMER_IRQ_EN: when defined, IM is stored and irq is driven;
//   otherwise irq is tied 0 and CTRL bit3 reads 0.
module timer
   import timer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   state_e             state_q, state_d;
   logic               en_q, en_d;
   logic [1:0]         mode_q, mode_d;
   logic [CNT_W-1:0]   preset_q, preset_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               wr_ctrl, wr_pre;
   logic               reload;
   logic               cnt_done;
   logic [31:0]        ctrl_rd;

   assign wr_ctrl  = we && (addr == CTRL_ADDR);
   assign wr_pre   = we && (addr == PRESET_ADDR);
   assign reload   = (mode_q == MODE_RELOAD);
   assign cnt_done = (state_q == CNT) && en_q && (count_q == '0);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (en_q) state_d = LOAD;
         LOAD: state_d = CNT;
         CNT: begin
            if (!en_q)              state_d = IDLE;
            else if (count_q == '0) state_d = INT;
         end
         INT:  state_d = IDLE;
      endcase
   end

   // Datapath next values; a CPU CTRL write overrides the
   // one-shot EN clear taken in INT.
   always_comb begin
      en_d     = en_q;
      mode_d   = mode_q;
      preset_d = preset_q;
      count_d  = count_q;
      unique case (state_q)
         LOAD: count_d = preset_q;
         CNT:  if (en_q && count_q != '0)
                  count_d = count_q - CNT_W'(1);
         INT:  if (!reload) en_d = 1'b0;
         default: ;
      endcase
      if (wr_ctrl) begin
         en_d   = din[CTRL_EN];
         mode_d = din[CTRL_MODE_HI:CTRL_MODE_LO];
      end
      if (wr_pre) preset_d = din[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q     <= 1'b0;
         mode_q   <= MODE_ONESHOT;
         preset_q <= '0;
         count_q  <= '0;
      end else begin
         en_q     <= en_d;
         mode_q   <= mode_d;
         preset_q <= preset_d;
         count_q  <= count_d;
      end
   end

`ifdef TIMER_IRQ_EN
   logic im_q, im_d;
   logic flag_q, flag_d;

   // Setting on CNT->INT wins so an interrupt is never lost.
   always_comb begin
      im_d   = im_q;
      flag_d = flag_q;
      if (wr_ctrl) im_d = din[CTRL_IM];
      if (cnt_done)
         flag_d = 1'b1;
      else if (wr_ctrl)
         flag_d = 1'b0;
      else if (state_q == INT && reload)
         flag_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_q   <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         im_q   <= im_d;
         flag_q <= flag_d;
      end
   end

   assign irq     = flag_q & im_q;
   assign ctrl_rd = {28'd0, im_q, mode_q, en_q};
`else
   logic unused_irq;
   assign unused_irq = cnt_done;
   assign irq        = 1'b0;
   assign ctrl_rd    = {28'd0, 1'b0, mode_q, en_q};
`endif

   // Read mux
   always_comb begin
      dout = '0;
      unique case (1'b1)
         addr == CTRL_ADDR:   dout = ctrl_rd;
         addr == PRESET_ADDR: dout = 32'(preset_q);
         addr == COUNT_ADDR:  dout = 32'(count_q);
         default:             dout = '0;
      endcase
   end

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for timer.
// Queued expects, monitor compares.
`timescale 1ns/1ps
module tb_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;
  logic        smp = 1'b0;

  timer #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #10 clk = ~clk;

`ifdef TIMER_IRQ_EN
  localparam logic        IRQ_ON = 1'b1;
  localparam logic [31:0] CMASK  = 32'hF;
`else
  localparam logic        IRQ_ON = 1'b0;
  localparam logic [31:0] CMASK  = 32'h7;
`endif

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
    logic        q;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  logic [31:0] rc [13] =
    '{0, 0, 2, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0};

  always @(negedge clk or posedge smp) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      total++;
      if (dout !== mon_e.d || irq !== mon_e.q) begin
        bad++;
        $display("FAIL %s: a=%0d d=%h i=%b want d=%h i=%b",
                 mon_e.nm, mon_e.a, dout, irq,
                 mon_e.d, mon_e.q);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: wait expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $finish;
  end

  function automatic logic [31:0] cr(input logic [31:0] v);
    return v & CMASK;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] a,
                      input logic [31:0] d,
                      input logic q, input string nm);
    exp_t e;
    e.a = a; e.d = d; e.q = q; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [1:0] a,
                     input logic [31:0] d,
                     input logic q, input string nm);
    addr = a;
    push(a, d, q, nm);
    step();
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
  endtask

  task automatic rst();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    total++;
    if (irq !== 1'b0 || dout !== 32'd0) begin
      bad++;
      $display("FAIL rst state: irq=%b dout=%h", irq, dout);
    end
    step();
    chk(0, 0, 0, "rst ctrl");
    chk(1, 0, 0, "rst preset");
    chk(2, 0, 0, "rst count");
    chk(3, 0, 0, "rst addr3");
    reset = 1'b1;

    wr(1, 3);
    wr(0, 9);
    chk(2, 0, 0, "os e0");
    chk(2, 0, 0, "os e1");
    chk(2, 3, 0, "os e2");
    chk(2, 2, 0, "os e3");
    chk(2, 1, 0, "os e4");
    chk(2, 0, 0, "os e5");
    chk(0, cr(9), IRQ_ON, "os int");
    chk(0, cr(8), IRQ_ON, "os en clr");
    chk(1, 3, IRQ_ON, "os held");
    wr(0, 0);
    chk(0, 0, 0, "os irq drop");

    wr(2, 32'hFF);
    wr(3, 32'hFF);
    chk(2, 0, 0, "count ro");
    chk(3, 0, 0, "addr3 zero");
    wr(1, 32'hDEADBEEF);
    chk(1, 32'hDEADBEEF, 0, "preset wide");
    wr(0, 32'hFFFFFFF4);
    chk(0, 4, 0, "ctrl bits");

    rst();
    wr(1, 2);
    wr(0, 11);
    for (int k = 0; k < 13; k++)
      chk(2, rc[k], (k == 5 || k == 11) ? IRQ_ON : 1'b0,
          $sformatf("rl e%0d", k));
    chk(0, cr(11), 0, "rl en kept");

    rst();
    wr(1, 10);
    wr(0, 9);
    repeat (5) step();
    chk(2, 7, 0, "dis e5");
    wr(0, 8);
    chk(2, 5, 0, "dis at5");
    chk(2, 5, 0, "dis idle");
    chk(2, 5, 0, "dis hold");
    chk(0, cr(8), 0, "dis ctrl");

    rst();
    wr(1, 0);
    wr(0, 9);
    chk(2, 0, 0, "p0 e0");
    chk(2, 0, 0, "p0 e1");
    chk(2, 0, 0, "p0 e2");
    chk(0, cr(9), IRQ_ON, "p0 irq e3");
    chk(0, cr(8), IRQ_ON, "p0 after");

    rst();
    wr(0, 9);
    repeat (3) step();
    wr(0, 9);
    chk(0, cr(9), 0, "prio en");
    step();
    step();
    chk(0, cr(9), IRQ_ON, "prio reint");
    chk(0, cr(8), IRQ_ON, "prio clr");

    rst();
    wr(1, 4);
    wr(0, 11);
    chk(2, 0, 0, "pw e0");
    chk(2, 0, 0, "pw e1");
    wr(1, 7);
    chk(2, 3, 0, "pw e3");
    chk(2, 2, 0, "pw e4");
    chk(2, 1, 0, "pw e5");
    chk(2, 0, 0, "pw e6");
    chk(2, 0, IRQ_ON, "pw int");
    chk(1, 7, 0, "pw preset");
    chk(2, 0, 0, "pw load");
    chk(2, 7, 0, "pw reload");
    chk(2, 6, 0, "pw dec");

    rst();
    wr(1, 1);
    wr(0, 1);
    repeat (3) step();
    chk(2, 0, 0, "im0 e3");
    chk(0, 1, 0, "im0 int");
    chk(0, 0, 0, "im0 en clr");

    rst();
    wr(1, 1);
    wr(0, 9);
    repeat (3) step();
    chk(2, 0, 0, "ri e3");
    addr = 0;
    push(0, cr(9), IRQ_ON, "ri pre");
    @(negedge clk);
    #1 reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      push(2'(a), 0, 0, $sformatf("ri addr%0d", a));
      #1 smp = 1'b1;
      #1 smp = 1'b0;
    end
    step();
    reset = 1'b1;
    chk(0, 0, 0, "ri post ctrl");
    chk(2, 0, 0, "ri post cnt");
    chk(1, 0, 0, "ri post pre");

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expects left", sbq.size());
    end

    if (bad == 0) $display("PASS");
    else          $display("FAIL");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
